mem_access_stage: RTL and testbench

Memory-access pipeline stage, the receiving end of the execute-to-memory interface. Accepts one executed instruction per handshake and issues loads and stores to a request/grant/rvalid data-memory port. Performs byte/halfword lane selection and extension. Presents a single-entry registered result to write-back with its own valid/ready handshake.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/mem_access_stage_if.sv | 25 ++
 rtl/load_extend.sv | 37 +++
 rtl/mem_access_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, load/store
// size codes and the memory-access FSM encoding.
package riscv_pkg;

  localparam int N = 32;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_REG_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG_REG = 7'b0110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/grant/rvalid data-memory port.
// master = memory stage, slave = memory.
interface mem_access_stage_if;
  import riscv_pkg::*;

  logic         req;
  logic         we;
  logic [N-1:0] addr;
  logic [3:0]   be;
  logic [N-1:0] wdata;
  logic         gnt;
  logic         rvalid;
  logic [N-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/load_extend.sv
// Load lane selection and sign/zero extension.
// Purely combinational so a cache path can share it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [N-1:0] rdata,
  input  logic [1:0]   a,
  input  logic [2:0]   funct3,
  output logic [N-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    case (a)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LBU:  data = {24'd0, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LHU:  data = {16'd0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues loads/stores and
// holds a single registered write-back result.
module mem_access_stage
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ex_valid,
  output logic         ex_ready,
  input  logic [N-1:0] ex_alu_result,
  input  logic [N-1:0] ex_rs2_data,
  input  logic [6:0]   ex_opcode,
  input  logic [2:0]   ex_funct3,
  input  logic [4:0]   ex_rd,
  mem_access_stage_if.master dmem,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic         wb_we,
  output logic [4:0]   wb_rd,
  output logic [N-1:0] wb_data,
  output logic         misaligned_err
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_REQ  = 2'(REQ);
  localparam logic [1:0] S_WAIT = 2'(WAIT_RD);

  logic [1:0]   state;
  logic [N-1:0] addr_q, wdata_q;
  logic [3:0]   be_q;
  logic         we_q;
  logic [1:0]   lane_q;
  logic [2:0]   f3_q;
  logic [4:0]   rd_q;
  logic         mis_q;

  logic         is_load, is_store, is_alu;
  logic         bad_f3, mis, accept;
  logic [1:0]   a;
  logic [3:0]   be_n;
  logic [N-1:0] wdata_n, ext_data;

  assign a = ex_alu_result[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_alu   = 1'b0;
    case (ex_opcode)
      OP_LOAD:    is_load  = 1'b1;
      OP_STORE:   is_store = 1'b1;
      OP_REG_REG,
      OP_REG_IMM,
      OP_JAL,
      OP_JALR:    is_alu   = 1'b1;
      default:    ;
    endcase
  end

  always_comb begin
    bad_f3 = 1'b0;
    if (is_load)
      bad_f3 = !(ex_funct3 inside
        {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    else if (is_store)
      bad_f3 = !(ex_funct3 inside
        {F3_SB, F3_SH, F3_SW});
  end

  // funct3[1:0] encodes size for both loads and stores
  assign mis = (is_load || is_store) &&
               (bad_f3 ||
                (ex_funct3[1:0] == 2'b01 && a[0]) ||
                (ex_funct3[1:0] == 2'b10 && a != 2'd0));

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = ex_rs2_data;
    unique case (1'b1)
      (ex_funct3 == F3_SB): begin
        be_n    = 4'b0001 << a;
        wdata_n = {4{ex_rs2_data[7:0]}};
      end
      (ex_funct3 == F3_SH): begin
        be_n    = a[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{ex_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ex_ready = (state == S_IDLE) &&
                    (!wb_valid || wb_ready);
  assign accept   = ex_valid && ex_ready;

  load_extend u_ext (
    .rdata  (dmem.rdata),
    .a      (lane_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      lane_q   <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      mis_q    <= 1'b0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      mis_q <= accept && mis;
      if (wb_valid && wb_ready)
        wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if ((is_load || is_store) && !mis) begin
              addr_q  <= {ex_alu_result[N-1:2], 2'b00};
              wdata_q <= wdata_n;
              be_q    <= is_store ? be_n : 4'b0000;
              we_q    <= is_store;
              lane_q  <= a;
              f3_q    <= ex_funct3;
              rd_q    <= ex_rd;
              state   <= S_REQ;
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= is_alu && (ex_rd != 5'd0);
              wb_rd    <= ex_rd;
              wb_data  <= is_alu ? ex_alu_result : '0;
            end
          end
        end
        S_REQ: begin
          if (dmem.gnt) begin
            if (we_q) begin
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= rd_q;
              wb_data  <= '0;
              state    <= S_IDLE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem.rvalid) begin
            wb_valid <= 1'b1;
            wb_we    <= (rd_q != 5'd0);
            wb_rd    <= rd_q;
            wb_data  <= ext_data;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dmem.req       = (state == S_REQ);
  assign dmem.we        = we_q;
  assign dmem.addr      = addr_q;
  assign dmem.be        = be_q;
  assign dmem.wdata     = wdata_q;
  assign misaligned_err = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage.
module tb_mem_access_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_rs2_data = '0;
  logic [6:0]  ex_opcode = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [4:0]  ex_rd = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned_err;

  mem_access_stage_if dmem ();

  mem_access_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_alu_result  (ex_alu_result),
    .ex_rs2_data    (ex_rs2_data),
    .ex_opcode      (ex_opcode),
    .ex_funct3      (ex_funct3),
    .ex_rd          (ex_rd),
    .dmem           (dmem.master),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .misaligned_err (misaligned_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Compare every retired result against the queue
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wb_valid && wb_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected got rd=%0d data=%h",
                 wb_rd, wb_data);
      end else begin
        e = sb.pop_front();
        if (wb_we !== e.we ||
            (e.we && wb_rd !== e.rd) ||
            (e.chk_data && wb_data !== e.data)) begin
          bad++;
          $display({"FAIL wb_result got we=%b rd=%0d ",
                    "data=%h want we=%b rd=%0d data=%h"},
                   wb_we, wb_rd, wb_data,
                   e.we, e.rd, e.data);
        end
      end
    end
  end

  function automatic void push(logic we, logic [4:0] rd,
                               logic [31:0] d, logic c);
    exp_t e;
    e.we = we; e.rd = rd; e.data = d; e.chk_data = c;
    sb.push_back(e);
  endfunction

  task automatic issue(input logic [6:0] op,
                       input logic [2:0] f3,
                       input logic [31:0] alu,
                       input logic [31:0] rs2,
                       input logic [4:0] rd);
    bit ok = 0;
    ex_opcode = op; ex_funct3 = f3;
    ex_alu_result = alu; ex_rs2_data = rs2;
    ex_rd = rd; ex_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ex_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL issue_timeout got ex_ready=0 want 1");
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dmem.req) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL req_timeout got req=0 want 1");
    end
  endtask

  task automatic do_load(input logic [31:0] addr,
                         input logic [2:0] f3,
                         input logic [4:0] rd,
                         input logic [31:0] rdata,
                         input logic [31:0] want,
                         input logic want_we);
    bit ok;
    push(want_we, rd, want, 1'b1);
    issue(OP_LOAD, f3, addr, 32'h0, rd);
    wait_req(ok);
    total++;
    if (dmem.addr !== {addr[31:2], 2'b00} ||
        dmem.we !== 1'b0) begin
      bad++;
      $display("FAIL load_req got addr=%h we=%b want %h 0",
               dmem.addr, dmem.we, {addr[31:2], 2'b00});
    end
    dmem.gnt = 1'b1;
    @(posedge clk); #1;
    dmem.gnt = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata = rdata;
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    dmem.rdata = $urandom;
  endtask

  task automatic test_reset;
    total++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0 ||
        wb_data !== 32'h0 || ex_ready !== 1'b1 ||
        dmem.req !== 1'b0 || misaligned_err !== 1'b0 ||
        dmem.be !== 4'h0) begin
      bad++;
      $display({"FAIL reset got v=%b we=%b d=%h rdy=%b ",
                "req=%b mis=%b want 0 0 0 1 0 0"},
               wb_valid, wb_we, wb_data, ex_ready,
               dmem.req, misaligned_err);
    end
  endtask

  task automatic test_alu;
    logic [6:0]  ops[5] = '{OP_REG_REG, OP_REG_IMM,
                            OP_JAL, OP_BRANCH, OP_REG_REG};
    logic [4:0]  rds[5] = '{5, 6, 1, 2, 0};
    logic [31:0] res[5] = '{32'h1234, 32'hCAFE_0001,
                            32'h8000_0004, 32'h55, 32'h77};
    wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (ops[i] == OP_BRANCH)
        push(1'b0, rds[i], 32'h0, 1'b1);
      else
        push(rds[i] != 0, rds[i], res[i], 1'b1);
      ex_opcode = ops[i]; ex_funct3 = 3'b000;
      ex_alu_result = res[i]; ex_rd = rds[i];
      ex_valid = 1'b1;
      @(negedge clk);
      total++;
      if (ex_ready !== 1'b1 ||
          (i > 0 && wb_valid !== 1'b1)) begin
        bad++;
        $display("FAIL alu_b2b_%0d got rdy=%b v=%b want 1 1",
                 i, ex_ready, wb_valid);
      end
      @(posedge clk); #1;
    end
    ex_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_store;
    logic [31:0] ad[3] = '{32'h103, 32'h102, 32'h204};
    logic [2:0]  f3[3] = '{F3_SB, F3_SH, F3_SW};
    logic [3:0]  be[3] = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] wd[3] = '{32'hDDDDDDDD, 32'hCCDDCCDD,
                           32'hAABBCCDD};
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 5'd9, 32'h0, 1'b1);
      issue(OP_STORE, f3[i], ad[i], 32'hAABBCCDD, 5'd9);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        total++;
        if (dmem.req !== 1'b1 || dmem.we !== 1'b1 ||
            dmem.addr !== {ad[i][31:2], 2'b00} ||
            dmem.be !== be[i] || dmem.wdata !== wd[i]) begin
          bad++;
          $display({"FAIL store_%0d_c%0d got req=%b we=%b ",
                    "a=%h be=%b wd=%h want 1 1 %h %b %h"},
                   i, c, dmem.req, dmem.we, dmem.addr,
                   dmem.be, dmem.wdata,
                   {ad[i][31:2], 2'b00}, be[i], wd[i]);
        end
        if (c == 3) dmem.gnt = 1'b1;
      end
      @(posedge clk); #1;
      dmem.gnt = 1'b0;
      @(negedge clk);
      total++;
      if (dmem.req !== 1'b0 || wb_valid !== 1'b1) begin
        bad++;
        $display("FAIL store_done_%0d got req=%b v=%b want 0 1",
                 i, dmem.req, wb_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load;
    wb_ready = 1'b1;
    do_load(32'h101, F3_LB, 5'd4, 32'h0000_8000,
            32'hFFFF_FF80, 1'b1);
    do_load(32'h101, F3_LBU, 5'd4, 32'h0000_8000,
            32'h0000_0080, 1'b1);
    do_load(32'h102, F3_LHU, 5'd8, 32'hBEEF_0000,
            32'h0000_BEEF, 1'b1);
    do_load(32'h102, F3_LH, 5'd8, 32'hBEEF_0000,
            32'hFFFF_BEEF, 1'b1);
    do_load(32'h100, F3_LW, 5'd10, 32'h1234_5678,
            32'h1234_5678, 1'b1);
    do_load(32'h100, F3_LW, 5'd0, 32'h1234_5678,
            32'h1234_5678, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned;
    logic [6:0]  op[3] = '{OP_LOAD, OP_STORE, OP_LOAD};
    logic [2:0]  f3[3] = '{F3_LW, 3'b011, F3_LH};
    logic [31:0] ad[3] = '{32'h102, 32'h100, 32'h103};
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 5'd7, 32'h0, 1'b1);
      issue(op[i], f3[i], ad[i], 32'h1, 5'd7);
      @(negedge clk);
      total++;
      if (misaligned_err !== 1'b1 || dmem.req !== 1'b0) begin
        bad++;
        $display("FAIL mis_%0d got err=%b req=%b want 1 0",
                 i, misaligned_err, dmem.req);
      end
      @(negedge clk);
      total++;
      if (misaligned_err !== 1'b0 || dmem.req !== 1'b0 ||
          ex_ready !== 1'b1) begin
        bad++;
        $display("FAIL mis_end_%0d got err=%b req=%b rdy=%b",
                 i, misaligned_err, dmem.req, ex_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    wb_ready = 1'b0;
    do_load(32'h300, F3_LW, 5'd7, 32'h1357_9BDF,
            32'h1357_9BDF, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h1357_9BDF ||
          wb_rd !== 5'd7 || wb_we !== 1'b1 ||
          ex_ready !== 1'b0 || dmem.req !== 1'b0) begin
        bad++;
        $display({"FAIL hold_%0d got v=%b d=%h rd=%0d ",
                  "rdy=%b req=%b want 1 13579bdf 7 0 0"},
                 c, wb_valid, wb_data, wb_rd,
                 ex_ready, dmem.req);
      end
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    bit ok;
    wb_ready = 1'b1;
    issue(OP_LOAD, F3_LW, 32'h400, 32'h0, 5'd3);
    wait_req(ok);
    dmem.gnt = 1'b1;
    @(posedge clk); #1;
    dmem.gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (wb_valid !== 1'b0 || dmem.req !== 1'b0 ||
        wb_data !== 32'h0 || dmem.addr !== 32'h0 ||
        ex_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid got v=%b req=%b a=%h rdy=%b",
               wb_valid, dmem.req, dmem.addr, ex_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem.rvalid = 1'b1;
    dmem.rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin
        bad++;
        $display("FAIL late_rvalid got v=%b d=%h want 0 0",
                 wb_valid, wb_data);
      end
    end
  endtask

  initial begin
    dmem.gnt = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_misaligned();
    test_backpressure();
    test_async_reset();
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got left=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
